// File: rtl/lsu_pkg.sv
// Shared encodings for the RV32 load/store unit: funct3 access sizes,
// WB result-source selects and the MEM-stage FSM state type.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef enum logic {S_IDLE, S_BUSY} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and lane replication,
// load byte/half extraction with sign/zero extension, misalignment detect.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeData,
  input  logic [31:0] rdWord,
  output logic        misalign,
  output logic [3:0]  byteEn,
  output logic [31:0] wrData,
  output logic [31:0] ldData
);
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  assign ldByte = rdWord[{addrLo, 3'b000} +: 8];
  assign ldHalf = addrLo[1] ? rdWord[31:16] : rdWord[15:0];

  // Size lives in funct3[1:0] for both load and store encodings.
  always_comb begin
    misalign = 1'b0;
    byteEn   = 4'b1111;
    wrData   = storeData;
    case (funct3[1:0])
      2'b00: begin
        byteEn = 4'b0001 << addrLo;
        wrData = {4{storeData[7:0]}};
      end
      2'b01: begin
        misalign = addrLo[0];
        byteEn   = addrLo[1] ? 4'b1100 : 4'b0011;
        wrData   = {2{storeData[15:0]}};
      end
      default: misalign = |addrLo;
    endcase
  end

  always_comb begin
    ldData = '0;
    case (funct3)
      F3_B:    ldData = {{24{ldByte[7]}}, ldByte};
      F3_BU:   ldData = {24'd0, ldByte};
      F3_H:    ldData = {{16{ldHalf[15]}}, ldHalf};
      F3_HU:   ldData = {16'd0, ldHalf};
      F3_W:    ldData = rdWord;
      default: ldData = '0;
    endcase
  end
endmodule

// File: rtl/mem_wb_stage_lsu.sv
// MEM stage of the RV32 pipeline: data memory, load/store with extension,
// multi-cycle load stall FSM, flush handling and the MEM/WB register.
module mem_wb_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 1024,
  parameter int LOAD_LAT = 1,
  parameter int REG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_m,
  output logic             ready_m,
  input  logic             flush,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  write_data_m,
  input  logic [XLEN-1:0]  pc_plus4_m,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic             mem_read_m,
  input  logic             mem_write_m,
  input  logic [2:0]       funct3_m,
  input  logic [1:0]       result_src_m,
  output logic             valid_w,
  output logic             reg_write_w,
  output logic [1:0]       result_src_w,
  output logic [XLEN-1:0]  alu_result_w,
  output logic [XLEN-1:0]  read_data_w,
  output logic [XLEN-1:0]  pc_plus4_w,
  output logic [REG_W-1:0] rd_w,
  output logic             misalign_w
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  if (XLEN != 32) begin : gXlenChk
    $error("mem_wb_stage_lsu: XLEN must be 32");
  end
  if (LOAD_LAT < 1 || LOAD_LAT > 4) begin : gLatChk
    $error("mem_wb_stage_lsu: LOAD_LAT must be 1..4");
  end

  logic [XLEN-1:0] mem [DEPTH];

  lsu_state_t state, nextState;
  logic [1:0] cnt;
  logic       busy, accept, goBusy, wbLoad;

  logic [XLEN-1:0]  capAddr_p0, capPc4_p0;
  logic [REG_W-1:0] capRd_p0;
  logic [2:0]       capF3_p0;
  logic [1:0]       capRs_p0;
  logic             capRegWrite_p0;

  logic [XLEN-1:0]  selAddr, selPc4;
  logic [REG_W-1:0] selRd;
  logic [2:0]       selF3;
  logic [1:0]       selRs;
  logic             selRegWrite, selLoad, selMemOp;

  logic        misalign, memMis;
  logic [3:0]  byteEn;
  logic [31:0] wrData, ldData;

  assign busy    = (state == S_BUSY);
  assign ready_m = (state == S_IDLE);
  assign accept  = valid_m & ready_m & ~flush;

  // While a load is stalled, the captured op drives the read/extend path.
  assign selAddr     = busy ? capAddr_p0     : alu_result_m;
  assign selPc4      = busy ? capPc4_p0      : pc_plus4_m;
  assign selRd       = busy ? capRd_p0       : rd_m;
  assign selF3       = busy ? capF3_p0       : funct3_m;
  assign selRs       = busy ? capRs_p0       : result_src_m;
  assign selRegWrite = busy ? capRegWrite_p0 : reg_write_m;
  assign selLoad     = busy | (mem_read_m & ~mem_write_m);
  assign selMemOp    = busy | mem_read_m | mem_write_m;

  lsu_align u_align (
    .funct3    (selF3),
    .addrLo    (selAddr[1:0]),
    .storeData (write_data_m),
    .rdWord    (mem[selAddr[AW+1:2]]),
    .misalign  (misalign),
    .byteEn    (byteEn),
    .wrData    (wrData),
    .ldData    (ldData)
  );

  assign memMis = misalign & selMemOp;
  assign goBusy = accept & selLoad & ~memMis & (LOAD_LAT > 1);
  assign wbLoad = busy ? ((cnt == 2'd0) & ~flush) : (accept & ~goBusy);

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: if (goBusy) nextState = S_BUSY;
      S_BUSY: if (flush || cnt == 2'd0) nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= nextState;
      if (goBusy)
        cnt <= CNT_INIT;
      else if (busy && cnt != 2'd0)
        cnt <= cnt - 2'd1;
    end
  end

  // p0: captured load fields held across the stall
  always_ff @(posedge clk) begin
    if (goBusy) begin
      capAddr_p0     <= alu_result_m;
      capPc4_p0      <= pc_plus4_m;
      capRd_p0       <= rd_m;
      capF3_p0       <= funct3_m;
      capRs_p0       <= result_src_m;
      capRegWrite_p0 <= reg_write_m;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && mem_write_m && !memMis) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i])
          mem[alu_result_m[AW+1:2]][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

  // p1: MEM/WB register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      rd_w         <= '0;
      misalign_w   <= 1'b0;
    end else if (wbLoad) begin
      valid_w      <= 1'b1;
      reg_write_w  <= selRegWrite & ~memMis;
      result_src_w <= selRs;
      alu_result_w <= selAddr;
      read_data_w  <= (selLoad && !memMis) ? ldData : '0;
      pc_plus4_w   <= selPc4;
      rd_w         <= selRd;
      misalign_w   <= memMis;
    end else begin
      valid_w     <= 1'b0;
      reg_write_w <= 1'b0;
    end
  end
endmodule
